multi_duration_meter: RTL



---
 rtl/multi_duration_meter.sv | 108 ++++++++++
 1 files changed

// File: rtl/multi_duration_meter.sv
// multi_duration_meter: per-channel period and high-time meter for asynchronous inputs.
// Define MULTI_DURATION_METER_GLITCH_FILTER_EN to insert a per-channel glitch filter.
module multi_duration_meter #(
    parameter int NCH        = 4,
    parameter int WIDTH      = 32,
    parameter int TIMEOUT    = 50_000_000,
    parameter int FILTER_LEN = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NCH-1:0]       d,
    output logic [NCH*WIDTH-1:0] period,
    output logic [NCH*WIDTH-1:0] high_time,
    output logic [NCH-1:0]       valid,
    output logic [NCH-1:0]       update,
    output logic [NCH-1:0]       level
);
    typedef enum logic {IDLE, ARMED} state_t;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TMO     = WIDTH'(TIMEOUT);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             sync1_q, s_q, prev_q, x, rise;
        state_t           state_q, state_d;
        logic [WIDTH-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
        logic [WIDTH-1:0] period_q, period_d, high_q, high_d;
        logic             valid_q, valid_d, update_q, update_d;
`ifdef MULTI_DURATION_METER_GLITCH_FILTER_EN
        logic       filt_q;
        logic [7:0] fcnt_q;
        // The filtered level flips only once s has disagreed with it for FILTER_LEN cycles.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                filt_q <= 1'b0;
                fcnt_q <= '0;
            end else if (s_q != filt_q) begin
                filt_q <= (fcnt_q == 8'(FILTER_LEN - 1)) ? s_q : filt_q;
                fcnt_q <= (fcnt_q == 8'(FILTER_LEN - 1)) ? '0 : fcnt_q + 8'd1;
            end else begin
                fcnt_q <= '0;
            end
        end
        assign x = filt_q;
`else
        assign x = s_q;
`endif
        assign rise = x & ~prev_q;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q   <= 1'b0;
                s_q       <= 1'b0;
                prev_q    <= 1'b0;
                state_q   <= IDLE;
                per_cnt_q <= '0;
                hi_cnt_q  <= '0;
                period_q  <= '0;
                high_q    <= '0;
                valid_q   <= 1'b0;
                update_q  <= 1'b0;
            end else begin
                sync1_q   <= d[i];
                s_q       <= sync1_q;
                prev_q    <= x;
                state_q   <= state_d;
                per_cnt_q <= per_cnt_d;
                hi_cnt_q  <= hi_cnt_d;
                period_q  <= period_d;
                high_q    <= high_d;
                valid_q   <= valid_d;
                update_q  <= update_d;
            end
        end
        always_comb begin
            state_d   = state_q;
            per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + ONE;
            hi_cnt_d  = (hi_cnt_q == CNT_MAX || !x) ? hi_cnt_q : hi_cnt_q + ONE;
            period_d  = period_q;
            high_d    = high_q;
            valid_d   = valid_q;
            update_d  = 1'b0;
            if (state_q == IDLE) begin
                per_cnt_d = rise ? ONE : per_cnt_q;
                hi_cnt_d  = rise ? ONE : hi_cnt_q;
                state_d   = rise ? ARMED : IDLE;
            end else if (rise) begin
                period_d  = per_cnt_q;
                high_d    = hi_cnt_q;
                valid_d   = 1'b1;
                update_d  = 1'b1;
                per_cnt_d = ONE;
                hi_cnt_d  = ONE;
            end else if (per_cnt_q >= TMO) begin
                period_d  = '0;
                high_d    = '0;
                valid_d   = 1'b0;
                update_d  = 1'b1;
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                state_d   = IDLE;
            end
        end
        assign period[i*WIDTH +: WIDTH]    = period_q;
        assign high_time[i*WIDTH +: WIDTH] = high_q;
        assign valid[i]                    = valid_q;
        assign update[i]                   = update_q;
        assign level[i]                    = x;
    end
endmodule
